// File: rtl/bill_validator.sv
// bill_validator
// Front end for the ticket machine FSM. It turns the raw bill-path optical
// sensor into clean one-cycle ten/twenty/eject pulses.
// It works in three parts:
//   - a 2-flop synchroniser and a DEB-cycle debounce filter,
//   - a bill-length counter,
//   - a classifier FSM (IDLE, MEASURE, REPORT, JAM, HOLDOFF).
//
// Ports:
//   clk     in   rising-edge system clock
//   clear   in   synchronous active-high reset
//   sense   in   raw asynchronous sensor, high while a bill occludes it
//   accept  in   ticket machine can take payment
//   ten     out  one-cycle pulse, valid ten bill
//   twenty  out  one-cycle pulse, valid twenty bill
//   eject   out  one-cycle pulse, bill rejected
//   busy    out  high whenever the FSM is not in IDLE
//
// Optional feature, enabled by defining the macro BILL_VALIDATOR_STATS_EN:
//   n_ten, n_twenty, n_eject  out [15:0]  saturating pulse counters,
//                                         zeroed by clear
module bill_validator #(
    parameter int DEB     = 4,
    parameter int CNT_W   = 8,
    parameter int T10_MIN = 20,
    parameter int T10_MAX = 40,
    parameter int T20_MIN = 60,
    parameter int T20_MAX = 80,
    parameter int GAP     = 2
) (
    input  logic clk,
    input  logic clear,
    input  logic sense,
    input  logic accept,
    output logic ten,
    output logic twenty,
    output logic eject,
    output logic busy
`ifdef BILL_VALIDATOR_STATS_EN
    ,
    output logic [15:0] n_ten,
    output logic [15:0] n_twenty,
    output logic [15:0] n_eject
`endif
);

    localparam int RUN_W = (DEB > 1) ? $clog2(DEB) : 1;
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [CNT_W-1:0] LEN_MAX = '1;
    localparam logic [CNT_W-1:0] LEN_JAM = LEN_MAX - 1'b1;
    localparam logic [CNT_W-1:0] L10_MIN = CNT_W'(T10_MIN);
    localparam logic [CNT_W-1:0] L10_MAX = CNT_W'(T10_MAX);
    localparam logic [CNT_W-1:0] L20_MIN = CNT_W'(T20_MIN);
    localparam logic [CNT_W-1:0] L20_MAX = CNT_W'(T20_MAX);

    generate
        if (!(T10_MAX < T20_MIN || T20_MAX < T10_MIN)) begin : g_bad_windows
            $error("bill_validator: ten and twenty length windows overlap");
        end
        if (GAP < 1 || DEB < 1) begin : g_bad_timing
            $error("bill_validator: GAP and DEB must be at least 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        MEASURE,
        REPORT,
        JAM,
        HOLDOFF
    } state_t;

    logic             sync_p0, sync_p1;
    logic             flt, flt_q;
    logic [RUN_W-1:0] run;
    logic             rise;

    state_t           state, state_d;
    logic [CNT_W-1:0] len, len_d;
    logic             acc_ok, acc_d;
    logic [GAP_W-1:0] gap, gap_d;
    logic             ten_d, twenty_d, eject_d, busy_d;
    logic             ok, in10, in20;

    // ---- stage p0/p1: synchroniser and debounce filter ----
    always_ff @(posedge clk) begin
        if (clear) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            flt     <= 1'b0;
            flt_q   <= 1'b0;
            run     <= '0;
        end else begin
            sync_p0 <= sense;
            sync_p1 <= sync_p0;
            flt_q   <= flt;
            if (sync_p1 != flt) begin
                if (run == RUN_W'(DEB - 1)) begin
                    flt <= ~flt;
                    run <= '0;
                end else begin
                    run <= run + 1'b1;
                end
            end else begin
                run <= '0;
            end
        end
    end

    // An edge rather than a level starts a measurement. A bill still
    // covering the sensor when HOLDOFF ends is therefore ignored until it
    // clears the sensor and covers it again.
    assign rise = flt & ~flt_q;

    assign ok   = acc_ok & accept;
    assign in10 = (len >= L10_MIN) && (len <= L10_MAX);
    assign in20 = (len >= L20_MIN) && (len <= L20_MAX);

    // ---- stage p2: measurement / classification FSM ----
    always_comb begin
        state_d  = state;
        len_d    = len;
        acc_d    = acc_ok;
        gap_d    = gap;
        ten_d    = 1'b0;
        twenty_d = 1'b0;
        eject_d  = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_d = MEASURE;
                    len_d   = CNT_W'(1);
                    acc_d   = accept;
                end
            end
            MEASURE: begin
                if (!flt) begin
                    state_d = REPORT;
                    if (ok && in10) begin
                        ten_d = 1'b1;
                    end else if (ok && in20) begin
                        twenty_d = 1'b1;
                    end else begin
                        eject_d = 1'b1;
                    end
                end else if (len == LEN_JAM) begin
                    // Counter pins at its maximum; the jam is reported once here.
                    state_d = JAM;
                    len_d   = LEN_MAX;
                    eject_d = 1'b1;
                end else begin
                    len_d = len + 1'b1;
                end
            end
            REPORT: begin
                state_d = HOLDOFF;
                gap_d   = '0;
            end
            JAM: begin
                if (!flt) begin
                    state_d = HOLDOFF;
                    gap_d   = '0;
                end
            end
            HOLDOFF: begin
                if (gap == GAP_W'(GAP - 1)) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state  <= IDLE;
            len    <= '0;
            acc_ok <= 1'b0;
            gap    <= '0;
            ten    <= 1'b0;
            twenty <= 1'b0;
            eject  <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_d;
            len    <= len_d;
            acc_ok <= acc_d;
            gap    <= gap_d;
            ten    <= ten_d;
            twenty <= twenty_d;
            eject  <= eject_d;
            busy   <= busy_d;
        end
    end

`ifdef BILL_VALIDATOR_STATS_EN
    // ---- statistics ----
    always_ff @(posedge clk) begin
        if (clear) begin
            n_ten    <= '0;
            n_twenty <= '0;
            n_eject  <= '0;
        end else begin
            if (ten && n_ten != 16'hFFFF) n_ten <= n_ten + 1'b1;
            if (twenty && n_twenty != 16'hFFFF) n_twenty <= n_twenty + 1'b1;
            if (eject && n_eject != 16'hFFFF) n_eject <= n_eject + 1'b1;
        end
    end
`endif

endmodule
